// File: rtl/hdmi_pkg.sv
// Shared types for the HDMI video path: pixel struct, pattern and generator state codes, bar colours.
package hdmi_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {PAT_BARS, PAT_CHECK, PAT_GRAD, PAT_GREY} pattern_e;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} gen_state_e;

    localparam rgb_t BAR_WHITE   = 24'hFFFFFF;
    localparam rgb_t BAR_YELLOW  = 24'hFFFF00;
    localparam rgb_t BAR_CYAN    = 24'h00FFFF;
    localparam rgb_t BAR_GREEN   = 24'h00FF00;
    localparam rgb_t BAR_MAGENTA = 24'hFF00FF;
    localparam rgb_t BAR_RED     = 24'hFF0000;
    localparam rgb_t BAR_BLUE    = 24'h0000FF;
    localparam rgb_t BAR_BLACK   = 24'h000000;

    function automatic rgb_t bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return BAR_WHITE;
            3'd1:    return BAR_YELLOW;
            3'd2:    return BAR_CYAN;
            3'd3:    return BAR_GREEN;
            3'd4:    return BAR_MAGENTA;
            3'd5:    return BAR_RED;
            3'd6:    return BAR_BLUE;
            default: return BAR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/hdmi_pattern_gen_if.sv
// Pixel stream between the pattern generator (master) and the HDMI transmitter (slave).
interface hdmi_pattern_gen_if;
    import hdmi_pkg::*;

    rgb_t video_out;
    logic video_valid;
    logic video_rdy;
    logic sof;
    logic eol;

    modport master (output video_out, output video_valid, output sof, output eol, input video_rdy);
    modport slave  (input video_out, input video_valid, input sof, input eol, output video_rdy);
endinterface

// File: rtl/hdmi_raster_cnt.sv
// Raster x/y/bar-index counters; registered position, exposes next position and flags combinationally.
// Position moves only when advance is high, so a stalled pixel keeps its coordinates.
module hdmi_raster_cnt #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    localparam int XW = $clog2(H_ACTIVE),
    localparam int YW = $clog2(V_ACTIVE)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          advance,
    output logic [XW-1:0] x_nxt,
    output logic [YW-1:0] y_nxt,
    output logic [2:0]    bar_nxt,
    output logic          sof_nxt,
    output logic          eol_nxt,
    output logic          last_pixel
);
    localparam int BAR_W = H_ACTIVE / 8;
    localparam int BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam logic [XW-1:0] X_LAST  = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(V_ACTIVE - 1);
    localparam logic [BW-1:0] BC_LAST = BW'(BAR_W - 1);

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [2:0]    r_bar;
    logic [BW-1:0] r_bcnt;
    logic [BW-1:0] w_bcnt_nxt;

    always_comb begin
        x_nxt      = r_x;
        y_nxt      = r_y;
        bar_nxt    = r_bar;
        w_bcnt_nxt = r_bcnt;
        if (advance) begin
            if (r_x == X_LAST) begin
                x_nxt      = '0;
                bar_nxt    = '0;
                w_bcnt_nxt = '0;
                y_nxt      = (r_y == Y_LAST) ? '0 : r_y + 1'b1;
            end else begin
                x_nxt = r_x + 1'b1;
                // Bar index saturates so any remainder pixels stay on the last bar.
                if (r_bcnt == BC_LAST) begin
                    w_bcnt_nxt = '0;
                    bar_nxt    = (r_bar == 3'd7) ? 3'd7 : r_bar + 3'd1;
                end else begin
                    w_bcnt_nxt = r_bcnt + 1'b1;
                end
            end
        end
    end

    assign sof_nxt    = (x_nxt == '0) && (y_nxt == '0);
    assign eol_nxt    = (x_nxt == X_LAST);
    assign last_pixel = (r_x == X_LAST) && (r_y == Y_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x    <= '0;
            r_y    <= '0;
            r_bar  <= '0;
            r_bcnt <= '0;
        end else begin
            r_x    <= x_nxt;
            r_y    <= y_nxt;
            r_bar  <= bar_nxt;
            r_bcnt <= w_bcnt_nxt;
        end
    end

endmodule

// File: rtl/hdmi_pattern_gen.sv
// Programmable raster pattern source; pixel (0,0) one cycle after enable, one pixel per cycle.
// Valid/rdy output: all outputs hold while stalled; pattern and stop take effect at frame boundaries.
module hdmi_pattern_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int CHECK_LOG2 = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [1:0]                pattern_sel,
    output logic [7:0]                frame_count,
    hdmi_pattern_gen_if.master        vid
);
    import hdmi_pkg::*;

    localparam int XW = $clog2(H_ACTIVE);
    localparam int YW = $clog2(V_ACTIVE);
    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_RUN   = RUN;
    localparam logic [1:0] S_DRAIN = DRAIN;

    logic [1:0]    r_state;
    pattern_e      r_pat;
    logic [7:0]    r_fc;
    rgb_t          r_out;
    logic          r_vld;
    logic          r_sof;
    logic          r_eol;

    logic [1:0]    w_state_nxt;
    pattern_e      w_pat_nxt;
    logic [7:0]    w_fc_nxt;
    rgb_t          w_pix;
    logic          w_xfer;
    logic          w_start;
    logic          w_last;
    logic          w_chk;
    logic [XW-1:0] w_x_nxt;
    logic [YW-1:0] w_y_nxt;
    logic [2:0]    w_bar_nxt;
    logic          w_sof_nxt;
    logic          w_eol_nxt;
    logic          w_last_pixel;

    hdmi_raster_cnt #(.H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE)) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .advance    (w_xfer),
        .x_nxt      (w_x_nxt),
        .y_nxt      (w_y_nxt),
        .bar_nxt    (w_bar_nxt),
        .sof_nxt    (w_sof_nxt),
        .eol_nxt    (w_eol_nxt),
        .last_pixel (w_last_pixel)
    );

    assign w_xfer    = r_vld && vid.video_rdy;
    assign w_start   = (r_state == S_IDLE) && enable;
    assign w_last    = w_xfer && w_last_pixel;
    assign w_pat_nxt = (w_start || w_last) ? pattern_e'(pattern_sel) : r_pat;
    assign w_fc_nxt  = w_last ? r_fc + 8'd1 : r_fc;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (enable) w_state_nxt = S_RUN;
            S_RUN:   if (!enable) w_state_nxt = S_DRAIN;
            S_DRAIN: begin
                if (enable)      w_state_nxt = S_RUN;
                else if (w_last) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Pixel is built from the next position so the output register lines up with the counters.
    assign w_chk = (|(w_x_nxt & XW'(32'd1 << CHECK_LOG2))) ^ (|(w_y_nxt & YW'(32'd1 << CHECK_LOG2)));

    always_comb begin
        w_pix = 24'h808080;
        case (w_pat_nxt)
            PAT_BARS:  w_pix = bar_colour(w_bar_nxt);
            PAT_CHECK: w_pix = w_chk ? 24'hFFFFFF : 24'h000000;
            PAT_GRAD:  w_pix = {8'(w_x_nxt), 8'(w_y_nxt), w_fc_nxt};
            default:   w_pix = 24'h808080;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pat   <= PAT_BARS;
            r_fc    <= '0;
            r_out   <= '0;
            r_vld   <= 1'b0;
            r_sof   <= 1'b0;
            r_eol   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pat   <= w_pat_nxt;
            r_fc    <= w_fc_nxt;
            if (w_state_nxt == S_IDLE) begin
                r_vld <= 1'b0;
                r_out <= '0;
                r_sof <= 1'b0;
                r_eol <= 1'b0;
            end else if (w_start || w_xfer) begin
                r_vld <= 1'b1;
                r_out <= w_pix;
                r_sof <= w_sof_nxt;
                r_eol <= w_eol_nxt;
            end
        end
    end

    assign vid.video_out   = r_out;
    assign vid.video_valid = r_vld;
    assign vid.sof         = r_sof;
    assign vid.eol         = r_eol;
    assign frame_count     = r_fc;

endmodule

// File: tb/tb_hdmi_pattern_gen.sv
// Bench for hdmi_pattern_gen: a 64x4 instance for patterns/drain/re-enable, a 16x2 instance for frame wrap.
module tb_hdmi_pattern_gen;
    import hdmi_pkg::*;

    localparam int HA = 64, VA = 4, NA = HA * VA;
    localparam int HB = 16, VB = 2, NB = HB * VB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       en_a, en_b, rdy_a, rdy_b;
    logic [1:0] sel_a, sel_b;
    logic [7:0] fc_a, fc_b;

    hdmi_pattern_gen_if if_a ();
    hdmi_pattern_gen_if if_b ();
    assign if_a.video_rdy = rdy_a;
    assign if_b.video_rdy = rdy_b;

    hdmi_pattern_gen #(.H_ACTIVE(HA), .V_ACTIVE(VA), .CHECK_LOG2(5)) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(en_a), .pattern_sel(sel_a), .frame_count(fc_a), .vid(if_a));
    hdmi_pattern_gen #(.H_ACTIVE(HB), .V_ACTIVE(VB), .CHECK_LOG2(5)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(en_b), .pattern_sel(sel_b), .frame_count(fc_b), .vid(if_b));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference pixel {rgb, sof, eol} from pixel index within a frame, straight from the pattern rules.
    function automatic logic [25:0] ref_entry(input int h, input int idx, input int pat, input int fc);
        int x, y, bar;
        logic [23:0] rgb;
        x = idx % h;
        y = idx / h;
        case (pat)
            0: begin
                bar = x / (h / 8);
                if (bar > 7) bar = 7;
                case (bar)
                    0: rgb = 24'hFFFFFF;
                    1: rgb = 24'hFFFF00;
                    2: rgb = 24'h00FFFF;
                    3: rgb = 24'h00FF00;
                    4: rgb = 24'hFF00FF;
                    5: rgb = 24'hFF0000;
                    6: rgb = 24'h0000FF;
                    default: rgb = 24'h000000;
                endcase
            end
            1: rgb = ((((x >> 5) ^ (y >> 5)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
            2: rgb = {8'(x), 8'(y), 8'(fc)};
            default: rgb = 24'h808080;
        endcase
        return {rgb, (x == 0 && y == 0), (x == h - 1)};
    endfunction

    task automatic check_frame(input string name, input int h, input int npix, input int off,
                               input int pat, input int fc, input logic [25:0] got[$]);
        int k;
        logic [25:0] act;
        k = npix - 1;
        for (int i = 0; i < npix; i++) begin
            if (off + i >= got.size() || got[off + i] !== ref_entry(h, i, pat, fc)) begin
                k = i;
                break;
            end
        end
        act = (off + k < got.size()) ? got[off + k] : '1;
        chk($sformatf("%s_fc%0d_px%0d", name, fc, k), 32'(act), 32'(ref_entry(h, k, pat, fc)));
    endtask

    // Monitors: capture every transfer and require exact hold across stalls.
    logic [25:0] cap_a[$], cap_b[$];
    logic [1:0]  hist_b[$];
    logic [25:0] prev_a, prev_b;
    logic        stall_a = 1'b0, stall_b = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_a = 1'b0;
            stall_b = 1'b0;
        end else begin
            if (stall_a) chk("stall_hold_a", {if_a.video_valid, if_a.video_out, if_a.sof, if_a.eol}, {1'b1, prev_a});
            if (stall_b) chk("stall_hold_b", {if_b.video_valid, if_b.video_out, if_b.sof, if_b.eol}, {1'b1, prev_b});
            if (if_a.video_valid && rdy_a) cap_a.push_back({if_a.video_out, if_a.sof, if_a.eol});
            if (if_b.video_valid && rdy_b) begin
                cap_b.push_back({if_b.video_out, if_b.sof, if_b.eol});
                if (cap_b.size() % NB == 0) hist_b.push_back(sel_b);
            end
            stall_a = if_a.video_valid && !rdy_a;
            stall_b = if_b.video_valid && !rdy_b;
            prev_a  = {if_a.video_out, if_a.sof, if_a.eol};
            prev_b  = {if_b.video_out, if_b.sof, if_b.eol};
        end
    end

    task automatic run_a();
        int n, base;
        bit fc1_done, ok;
        fc1_done = 0;
        ok = 0;
        // Phase 1: patterns 0,2,1,3 at full rate, then two frames under backpressure, drain mid-frame 5.
        for (int c = 0; c < 20000; c++) begin
            @(posedge clk); #1;
            n = cap_a.size();
            if (n >= 6 * NA && !if_a.video_valid) begin ok = 1; break; end
            rdy_a = (n >= 4 * NA) ? 1'($urandom_range(0, 1)) : 1'b1;
            case (n)
                100:  sel_a = 2'd2;
                356:  sel_a = 2'd1;
                612:  sel_a = 2'd3;
                868:  sel_a = 2'd0;
                1124: sel_a = 2'd2;
                1380: en_a  = 1'b0;
                default: ;
            endcase
            if (n == NA && !fc1_done) begin
                chk("fc_after_frame0", 32'(fc_a), 32'd1);
                fc1_done = 1;
            end
        end
        chk("a_drain_done", 32'(ok), 32'd1);
        chk("a_idle_valid", 32'(if_a.video_valid), 32'd0);
        chk("a_fc_after_drain", 32'(fc_a), 32'd6);
        rdy_a = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("a_no_extra_pixels", 32'(cap_a.size()), 32'(6 * NA));

        // Phase 2: restart, drain, re-enable on the last beat with a pattern change that same cycle.
        base = cap_a.size();
        sel_a = 2'd1;
        en_a  = 1'b1;
        @(posedge clk); #1;
        chk("restart_valid", 32'(if_a.video_valid), 32'd1);
        chk("restart_sof", 32'(if_a.sof), 32'd1);
        chk("restart_out", 32'(if_a.video_out), 32'h000000);
        repeat (10) @(posedge clk);
        #1;
        en_a = 1'b0;
        ok = 0;
        for (int c = 0; c < 2000; c++) begin
            if (cap_a.size() == base + NA - 1) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        chk("a_reach_last_pixel", 32'(ok), 32'd1);
        chk("last_pixel_eol", 32'(if_a.eol), 32'd1);
        en_a  = 1'b1;
        sel_a = 2'd3;
        @(posedge clk); #1;
        chk("reenable_valid", 32'(if_a.video_valid), 32'd1);
        chk("reenable_sof", 32'(if_a.sof), 32'd1);
        chk("reenable_out", 32'(if_a.video_out), 32'h808080);
        chk("reenable_fc", 32'(fc_a), 32'd7);
        en_a = 1'b0;
        ok = 0;
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #1;
            if (!if_a.video_valid) begin ok = 1; break; end
        end
        chk("a_second_drain_done", 32'(ok), 32'd1);
        chk("a_fc_final", 32'(fc_a), 32'd8);
    endtask

    task automatic run_b();
        int n;
        bit f255_done, wrap_done, ok;
        f255_done = 0;
        wrap_done = 0;
        ok = 0;
        for (int c = 0; c < 40000; c++) begin
            @(posedge clk); #1;
            n = cap_b.size();
            if (n >= 257 * NB && !if_b.video_valid) begin ok = 1; break; end
            rdy_b = ($urandom_range(0, 3) != 0);
            sel_b = (n >= 255 * NB && n < 256 * NB) ? 2'd2 : 2'($urandom_range(0, 3));
            if (n == 256 * NB + 5) en_b = 1'b0;
            if (n == 255 * NB && !f255_done) begin
                chk("fc_at_255", 32'(fc_b), 32'd255);
                f255_done = 1;
            end
            if (n == 256 * NB && !wrap_done) begin
                chk("fc_wrap", 32'(fc_b), 32'd0);
                chk("wrap_sof", 32'({if_b.video_valid, if_b.sof}), 32'h3);
                chk("wrap_grad_b", 32'(if_b.video_out.b), 32'd0);
                wrap_done = 1;
            end
        end
        chk("b_drain_done", 32'(ok), 32'd1);
    endtask

    typedef struct {
        string       name;
        int          idx;
        logic [23:0] rgb;
        logic        sof;
        logic        eol;
    } vec_t;

    vec_t tbl[$];
    int   pats_a[8];

    initial begin
        pats_a = '{0, 2, 1, 3, 0, 2, 1, 3};
        tbl.push_back('{"bar0_first", 0,   24'hFFFFFF, 1'b1, 1'b0});
        tbl.push_back('{"bar0_end",   7,   24'hFFFFFF, 1'b0, 1'b0});
        tbl.push_back('{"bar1",       8,   24'hFFFF00, 1'b0, 1'b0});
        tbl.push_back('{"bar2",       16,  24'h00FFFF, 1'b0, 1'b0});
        tbl.push_back('{"bar3",       24,  24'h00FF00, 1'b0, 1'b0});
        tbl.push_back('{"bar4",       32,  24'hFF00FF, 1'b0, 1'b0});
        tbl.push_back('{"bar5",       40,  24'hFF0000, 1'b0, 1'b0});
        tbl.push_back('{"bar6",       48,  24'h0000FF, 1'b0, 1'b0});
        tbl.push_back('{"bar7",       56,  24'h000000, 1'b0, 1'b0});
        tbl.push_back('{"bar7_eol",   63,  24'h000000, 1'b0, 1'b1});
        tbl.push_back('{"line1_x0",   64,  24'hFFFFFF, 1'b0, 1'b0});
        tbl.push_back('{"bars_after_sel_change", 150, 24'h00FFFF, 1'b0, 1'b0});
        tbl.push_back('{"frame0_last", 255, 24'h000000, 1'b0, 1'b1});
        tbl.push_back('{"grad_sof",   256, 24'h000001, 1'b1, 1'b0});
        tbl.push_back('{"grad_x5_y1", 325, 24'h050101, 1'b0, 1'b0});
        tbl.push_back('{"check_x31",  543, 24'h000000, 1'b0, 1'b0});
        tbl.push_back('{"check_x32",  544, 24'hFFFFFF, 1'b0, 1'b0});
        tbl.push_back('{"check_x40_y1", 616, 24'hFFFFFF, 1'b0, 1'b0});
        tbl.push_back('{"grey",       968, 24'h808080, 1'b0, 1'b0});

        rst_n = 1'b0;
        en_a = 1'b1; en_b = 1'b1;
        sel_a = 2'd0; sel_b = 2'd2;
        rdy_a = 1'b1; rdy_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(if_a.video_valid), 32'd0);
        chk("rst_out", 32'(if_a.video_out), 32'd0);
        chk("rst_sof_eol", 32'({if_a.sof, if_a.eol}), 32'd0);
        chk("rst_fc", 32'(fc_a), 32'd0);
        chk("rst_valid_b", 32'(if_b.video_valid), 32'd0);
        hist_b.push_back(2'd2);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("start_valid", 32'(if_a.video_valid), 32'd1);
        chk("start_sof", 32'(if_a.sof), 32'd1);
        chk("start_out", 32'(if_a.video_out), 32'hFFFFFF);

        fork
            run_a();
            run_b();
        join

        chk("a_total_pixels", 32'(cap_a.size()), 32'(8 * NA));
        for (int f = 0; f < 8; f++) check_frame("a_frame", HA, NA, f * NA, pats_a[f], f, cap_a);
        foreach (tbl[i]) begin
            logic [25:0] got;
            got = (tbl[i].idx < cap_a.size()) ? cap_a[tbl[i].idx] : '1;
            chk(tbl[i].name, 32'(got), 32'({tbl[i].rgb, tbl[i].sof, tbl[i].eol}));
        end
        chk("b_total_pixels", 32'(cap_b.size()), 32'(257 * NB));
        for (int f = 0; f < 257; f++) begin
            int pat;
            pat = (f < hist_b.size()) ? int'(hist_b[f]) : 0;
            check_frame("b_frame", HB, NB, f * NB, pat, f % 256, cap_b);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
